data_unscale: RTL
=================

# data_unscale

Converts Goertzel-path 8.24 signed fixed-point values back to the 8-bit unsigned sample domain. It is the inverse of the input scaler, which multiplies samples by 13/256. The block computes code = round(x · 256/13) with a multi-cycle restoring divider and saturates the result to 0..255. It sits at the pipeline output and feeds 8-bit consumers such as the UART/debug readback and the threshold logic.

## Interface
- DIVISOR, 32'd851968: 13·2^16, the raw-LSB divisor equivalent to dividing an 8.24 value by 13/256.
- QBITS, 12: quotient width and divide iteration count. The design rule is (2^31 − 1 + DIVISOR/2) / DIVISOR < 2^QBITS.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input word valid.
- ready_o  out  1  block can accept a word.
- data_i  in  32  signed 8.24 input value.
- valid_o  out  1  result valid; held until accepted.
- ready_i  in  1  downstream accepts the result.
- data_o  out  8  unsigned result code.
- sat_o  out  1  result was clamped (negative input, or quotient > 255).

## Operation
- FSM states: IDLE, DIV, OUT. Reset state is IDLE.
- ready_o = (state == IDLE).
- **Accept (IDLE):** on valid_i & ready_o:
  - Negative data_i: dividend = 0, neg flag = 1.
  - Otherwise: dividend = data_i + DIVISOR/2 (32-bit unsigned, no overflow), neg flag = 0.
  - Clear quotient, set iteration counter to QBITS−1, go to DIV.
- **DIV:** one restoring step per clock.
  - trial = rem − (DIVISOR << cnt), computed at QBITS+32 bits.
  - If trial ≥ 0: rem = trial, quotient bit[cnt] = 1. Otherwise quotient bit[cnt] = 0.
  - When cnt == 0, go to OUT. Otherwise decrement cnt.
- **Enter OUT:**
  - If neg flag: data_o = 0, sat_o = 1.
  - Else if quotient > 255: data_o = 255, sat_o = 1.
  - Else: data_o = quotient[7:0], sat_o = 0.
  - valid_o = 1.
- **OUT:**
  - data_o, sat_o and valid_o stay stable while ready_i = 0.
  - On ready_i = 1: valid_o = 0, go to IDLE.
  - No new word is accepted in the same cycle.
- Negative inputs still run all QBITS steps (dividend 0), so latency is fixed.
- Rounding is round-half-up in the code domain.

## Timing
- Reset values: valid_o = 0, ready_o = 1 (IDLE), data_o = 0, sat_o = 0. Quotient, remainder and counter are all 0.
- Accept edge A → QBITS DIV edges → valid_o = 1 after edge A+QBITS (12 cycles at default).
- Result accepted at edge B (valid_o & ready_i) → ready_o = 1 after edge B. The next accept is possible at edge B+1.
- Minimum throughput: one word per QBITS+2 cycles.
- valid_i while not ready_o: ignored; the source must hold its word.
- valid_i is sampled only in IDLE. ready_i is sampled only in OUT.
- rstn asserted mid-divide or in OUT: immediate return to reset values. The in-flight word is discarded and no partial result is emitted.

## Structure
- Package dsp_scale_pkg holds:
  - SCALE_COEF (8.24 value 0x000D0000) and DIVISOR (13·2^16). The forward scaler and this block share these constants.
  - The state enum {IDLE, DIV, OUT}.
- Optional sub-module: restoring_div_step, the combinational single step (rem, divisor shift, quotient bit). The FSM, counter and handshake stay in data_unscale.

## Test plan
- Exact round-trip: data_i = 0x05140000 (100·DIVISOR) → data_o = 100, sat_o = 0, valid_o exactly 12 cycles after accept.
- Rounding boundary: 0x051A7FFF → 100; 0x051A8000 → 101, sat_o = 0.
- Full scale and overflow:
  - 0x0CF30000 → 255, sat_o = 0.
  - 0x0D000000 → 255, sat_o = 1.
  - 0x7FFFFFFF → 255, sat_o = 1.
- Negative input: 0xFFFFFFFF and 0x80000000 → data_o = 0, sat_o = 1, same 12-cycle latency.
- Backpressure: hold ready_i = 0 for 20 cycles in OUT → data_o/valid_o stable, ready_o = 0, a valid_i pulse is ignored; release → IDLE the next cycle, then the next word is accepted.
- Reset mid-op: assert rstn low at iteration 6 → all outputs at reset values, no valid_o pulse. After release, a fresh word yields its correct result.

Source files
------------

// File: rtl/dsp_scale_pkg.sv
// -----------------------------------------------------------------------------
// dsp_scale_pkg
// Constants and types shared between the forward input scaler and the
// data_unscale output converter.
//   SCALE_COEF : 8.24 coefficient 13/256 used by the forward scaler
//   DIVISOR    : 13 * 2^16, the raw-LSB divisor that undoes SCALE_COEF
//   QBITS_DEF  : default quotient width / divide iteration count
//   state_t    : data_unscale control states
// -----------------------------------------------------------------------------
package dsp_scale_pkg;

    localparam logic [31:0] SCALE_COEF = 32'h000D_0000;
    localparam logic [31:0] DIVISOR    = 32'd851968;
    localparam int          QBITS_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// -----------------------------------------------------------------------------
// restoring_div_step
// One combinational step of a restoring divider. Subtracts the divisor,
// shifted left by the current bit position, from the running remainder and
// keeps the difference only when it does not go negative.
//   rem      : running remainder (unsigned)
//   cnt      : quotient bit position handled by this step
//   rem_next : remainder after this step
//   qbit     : quotient bit produced at position cnt
// -----------------------------------------------------------------------------
module restoring_div_step
    import dsp_scale_pkg::*;
#(
    parameter int          QBITS   = QBITS_DEF,
    parameter logic [31:0] DIVISOR = dsp_scale_pkg::DIVISOR,
    parameter int          CW      = $clog2(QBITS)
) (
    input  logic [31:0]   rem,
    input  logic [CW-1:0] cnt,
    output logic [31:0]   rem_next,
    output logic          qbit
);

    localparam int TW = QBITS + 32;

    logic signed [TW-1:0] shifted;
    logic signed [TW-1:0] trial;

    always_comb begin
        // Extra QBITS of headroom keep the shifted divisor and the sign of
        // the difference exact for every bit position.
        shifted  = signed'({{QBITS{1'b0}}, DIVISOR} << cnt);
        trial    = signed'({{QBITS{1'b0}}, rem}) - shifted;
        qbit     = ~trial[TW-1];
        rem_next = qbit ? trial[31:0] : rem;
    end

endmodule

// File: rtl/data_unscale.sv
// -----------------------------------------------------------------------------
// data_unscale
// Converts Goertzel-path 8.24 signed values back to 8-bit unsigned sample
// codes: code = round(x * 256/13), clamped to 0..255. The division runs as a
// fixed-latency multi-cycle restoring divider (one quotient bit per clock).
//   clk, rstn : clock, asynchronous active-low reset
//   valid_i   : input word valid          ready_o : block idle, can accept
//   data_i    : signed 8.24 input value
//   valid_o   : result valid, held until accepted
//   ready_i   : downstream accepts the result
//   data_o    : unsigned result code      sat_o   : result was clamped
// -----------------------------------------------------------------------------
module data_unscale
    import dsp_scale_pkg::*;
#(
    parameter logic [31:0] DIVISOR = dsp_scale_pkg::DIVISOR,
    parameter int          QBITS   = QBITS_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic signed [31:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [7:0]         data_o,
    output logic               sat_o
);

    localparam int CW = $clog2(QBITS);

    state_t            state;
    logic [31:0]       rem;
    logic [QBITS-1:0]  quot;
    logic [CW-1:0]     cnt;
    logic              neg;

    logic [31:0]       rem_next;
    logic              qbit;
    logic [QBITS-1:0]  quot_next;
    logic [8:0]        sat_res;

    // Adding half the divisor up front turns the truncating divide into
    // round-half-up in the code domain. Non-negative 32-bit inputs plus this
    // bias always fit in 32 unsigned bits.
    function automatic logic [31:0] round_bias(input logic signed [31:0] x);
        return unsigned'(x) + (DIVISOR >> 1);
    endfunction

    // Returns {sat, code}.
    function automatic logic [8:0] saturate(input logic [QBITS-1:0] q,
                                            input logic             is_neg);
        if (is_neg)
            return {1'b1, 8'h00};
        else if (q > QBITS'(255))
            return {1'b1, 8'hFF};
        else
            return {1'b0, q[7:0]};
    endfunction

    restoring_div_step #(
        .QBITS   (QBITS),
        .DIVISOR (DIVISOR),
        .CW      (CW)
    ) u_step (
        .rem      (rem),
        .cnt      (cnt),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_comb begin
        quot_next      = quot;
        quot_next[cnt] = qbit;
        sat_res        = saturate(quot_next, neg);
    end

    assign ready_o = (state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            sat_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        // Negative inputs still run the full divide on a zero
                        // dividend so latency never depends on the data.
                        if (data_i < 0) begin
                            rem <= '0;
                            neg <= 1'b1;
                        end else begin
                            rem <= round_bias(data_i);
                            neg <= 1'b0;
                        end
                        quot  <= '0;
                        cnt   <= CW'(QBITS - 1);
                        state <= DIV;
                    end
                end

                DIV: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    if (cnt == '0) begin
                        // Last bit: register the clamped result together with
                        // valid so the outputs change in one step.
                        data_o  <= sat_res[7:0];
                        sat_o   <= sat_res[8];
                        valid_o <= 1'b1;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                OUT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
